// File: rtl/fetch_ctrl.sv
// Program sequencer behind the ALU: owns the fetch PC, the architectural FLAG/OVERFLOW
// registers, a branch-target lookup table and the START/DONE run handshake.
module fetch_ctrl #(
  parameter int                PC_W     = 10,
  parameter int                IDX_W    = 4,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              HALT,
  input  logic              BRANCH_EN,
  input  logic [IDX_W-1:0]  BRANCH_IDX,
  input  logic              LUT_WE,
  input  logic [IDX_W-1:0]  LUT_WADDR,
  input  logic [PC_W-1:0]   LUT_WDATA,
  input  logic              STATUS_WE,
  input  logic              FLAG_NEXT,
  input  logic              OVERFLOW_NEXT,
  output logic [PC_W-1:0]   PC,
  output logic              FETCH_VALID,
  output logic              FLAG,
  output logic              OVERFLOW,
  output logic              DONE,
  output logic [15:0]       CYCLE_COUNT
);

  localparam int LUT_N = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              flag_q, flag_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [PC_W-1:0]   lut_q [LUT_N];
  logic [PC_W-1:0]   lut_d [LUT_N];
  logic [PC_W-1:0]   branch_target;

  // Branch reads the registered table, so a same-cycle write is seen only next cycle.
  assign branch_target = lut_q[BRANCH_IDX];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          cnt_d   = '0;
          flag_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (STATUS_WE) begin
          flag_d = FLAG_NEXT;
          ovf_d  = OVERFLOW_NEXT;
        end
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (HALT) begin
          state_d = S_DONE;
        end else if (BRANCH_EN) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < LUT_N; i++) begin
      lut_d[i] = lut_q[i];
    end
    if (LUT_WE) begin
      lut_d[LUT_WADDR] = LUT_WDATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= lut_d[i];
      end
    end
  end

  assign PC          = pc_q;
  assign FLAG        = flag_q;
  assign OVERFLOW    = ovf_q;
  assign CYCLE_COUNT = cnt_q;
  assign FETCH_VALID = (state_q == S_RUN);
  assign DONE        = (state_q == S_DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl against a behavioural run/halt model.
module tb_fetch_ctrl;

  localparam int PC_W  = 10;
  localparam int IDX_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, halt, br_en, lut_we, st_we, flag_nx, ovf_nx;
  logic [IDX_W-1:0]  br_idx, lut_wa;
  logic [PC_W-1:0]   lut_wd;
  logic [PC_W-1:0]   pc;
  logic              fvalid, flag, ovf, done;
  logic [15:0]       ccount;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0=idle, 1=running, 2=finished.
  int m_mode, m_pc, m_flag, m_ovf, m_cnt;
  int m_lut [16];

  fetch_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .RESET_PC('0)) dut (
    .CLK(clk), .RESET(rst), .START(start), .HALT(halt),
    .BRANCH_EN(br_en), .BRANCH_IDX(br_idx),
    .LUT_WE(lut_we), .LUT_WADDR(lut_wa), .LUT_WDATA(lut_wd),
    .STATUS_WE(st_we), .FLAG_NEXT(flag_nx), .OVERFLOW_NEXT(ovf_nx),
    .PC(pc), .FETCH_VALID(fvalid), .FLAG(flag), .OVERFLOW(ovf),
    .DONE(done), .CYCLE_COUNT(ccount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_flag = 0; m_ovf = 0; m_cnt = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
  endtask

  task automatic model_edge();
    int old_target;
    old_target = m_lut[br_idx];
    if (m_mode == 1) begin
      if (st_we) begin m_flag = flag_nx; m_ovf = ovf_nx; end
      if (m_cnt < 65535) m_cnt++;
      if (halt)       m_mode = 2;
      else if (br_en) m_pc = old_target;
      else            m_pc = (m_pc + 1) % 1024;
    end else if (start) begin
      m_mode = 1; m_pc = 0; m_cnt = 0; m_flag = 0; m_ovf = 0;
    end
    if (lut_we) m_lut[lut_wa] = lut_wd;
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".pc"},    32'(pc),     32'(m_pc));
    check({ctx, ".valid"}, 32'(fvalid), 32'(m_mode == 1));
    check({ctx, ".done"},  32'(done),   32'(m_mode == 2));
    check({ctx, ".flag"},  32'(flag),   32'(m_flag));
    check({ctx, ".ovf"},   32'(ovf),    32'(m_ovf));
    check({ctx, ".cnt"},   32'(ccount), 32'(m_cnt));
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; br_en = 0; br_idx = '0; lut_we = 0; lut_wa = '0;
    lut_wd = '0; st_we = 0; flag_nx = 0; ovf_nx = 0;
  endtask

  // Inputs are set at the falling edge before calling; the model sees the same values.
  task automatic step(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    $display("cyc %s: pc=%0h valid=%0b done=%0b flag=%0b ovf=%0b cnt=%0d",
             ctx, pc, fvalid, done, flag, ovf, ccount);
    check_all(ctx);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Status write while idle must be ignored.
    st_we = 1; flag_nx = 1; ovf_nx = 1;
    step("idle_status");

    // LUT setup in idle, then start.
    lut_we = 1; lut_wa = 4'd3; lut_wd = 10'h155; step("lut3");
    lut_we = 1; lut_wa = 4'd5; lut_wd = 10'h3FE; step("lut5");
    lut_we = 1; lut_wa = 4'd7; lut_wd = 10'h040; step("lut7");
    start = 1; step("start");
    step("seq1"); step("seq2"); step("seq3");

    // Branch with same-cycle overwrite: first branch sees the old entry.
    br_en = 1; br_idx = 4'd3; lut_we = 1; lut_wa = 4'd3; lut_wd = 10'h0AA; step("br_old");
    br_en = 1; br_idx = 4'd3; step("br_new");

    // Wrap 0x3FE -> 0x3FF -> 0x000.
    br_en = 1; br_idx = 4'd5; step("to_3fe");
    step("to_3ff"); step("wrap");

    // Status commit in run with one-cycle visibility.
    st_we = 1; flag_nx = 1; ovf_nx = 1; step("status_run");

    // Halt wins over branch; status commits on halt cycle.
    lut_we = 1; lut_wa = 4'd9; lut_wd = 10'h020; step("lut9");
    br_en = 1; br_idx = 4'd9; step("to_020");
    halt = 1; br_en = 1; br_idx = 4'd3; st_we = 1; flag_nx = 0; ovf_nx = 1; step("halt");
    st_we = 1; flag_nx = 1; ovf_nx = 0; step("done_status");
    step("done_hold");
    start = 1; step("restart");

    // Asynchronous reset between edges at PC=0x040.
    br_en = 1; br_idx = 4'd7; step("to_040");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 3) == 0);
      halt    = ($urandom_range(0, 19) == 0);
      br_en   = ($urandom_range(0, 3) == 0);
      br_idx  = IDX_W'($urandom);
      lut_we  = ($urandom_range(0, 2) == 0);
      lut_wa  = IDX_W'($urandom);
      lut_wd  = PC_W'($urandom);
      st_we   = $urandom_range(0, 1) == 1;
      flag_nx = $urandom_range(0, 1) == 1;
      ovf_nx  = $urandom_range(0, 1) == 1;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
